// File: rtl/dcache_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer_pkg
//   Shared definitions for the data-cache posted write buffer.
//   - WORD_SIZE     : machine word width (address and data)
//   - wb_state_e    : drain/read FSM state encoding (WB_IDLE / WB_WR / WB_RD)
//   - clog2_min1()  : ceil(log2(v)) clamped to at least 1 bit, used to size
//                     counters whose load value can be zero
// -----------------------------------------------------------------------------
package dcache_write_buffer_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WR   = 2'd1,
    WB_RD   = 2'd2
  } wb_state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dcache_write_buffer_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
//   Storage for posted writes: a DEPTH-entry {addr, data} FIFO with an
//   associative lookup that returns the data of the youngest entry whose
//   address matches lookup_addr.
//
// Ports
//   clk, reset_n            : clock (rising edge), async active-low reset
//   push, push_addr/data    : enqueue request (ignored while full)
//   pop                     : dequeue head (ignored while empty)
//   lookup_addr             : address compared against every valid entry
//   full, empty             : occupancy flags derived from the pointers
//   head_addr, head_data    : oldest entry
//   hit, hit_data           : youngest-match lookup result
// -----------------------------------------------------------------------------
module wbuf_fifo
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WORD  = WORD_SIZE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [WORD-1:0] push_addr,
  input  logic [WORD-1:0] push_data,
  input  logic            pop,
  input  logic [WORD-1:0] lookup_addr,
  output logic            full,
  output logic            empty,
  output logic [WORD-1:0] head_addr,
  output logic [WORD-1:0] head_data,
  output logic            hit,
  output logic [WORD-1:0] hit_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count;
  logic [AW-1:0]   idx;
  logic [WORD-1:0] addr_mem_q [DEPTH];
  logic [WORD-1:0] data_mem_q [DEPTH];

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

  assign head_addr = addr_mem_q[rd_ptr_q[AW-1:0]];
  assign head_data = data_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Walk entries oldest to youngest; a later match overrides an earlier one,
  // so the result is always the most recently posted write to that address.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q[AW-1:0] + AW'(i);
      if ((PW'(i) < count) && (addr_mem_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry contents need no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      addr_mem_q[wr_ptr_q[AW-1:0]] <= push_addr;
      data_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer
//   Posted write buffer between the data cache and the data-memory port.
//   Writes are accepted in one cycle into wbuf_fifo and drained in the
//   background; reads forward from the youngest buffered write or go to
//   memory ahead of pending drains (a drain already started is never aborted).
//
// Ports
//   clk, reset_n                 : clock, async active-low reset
//   up_read/up_write/up_addr/    : cache request (held until up_done)
//   up_wdata
//   up_rdata, up_done            : completion and read data
//   readM2, writeM2, address2,   : memory port, strobes held MEM_LATENCY
//   mem_wdata, mem_rdata           cycles with stable address/data
//   empty                        : nothing buffered and FSM idle
//
// FSM
//   state   | meaning
//   WB_IDLE | strobes low; pick read miss first, else drain head
//   WB_WR   | writeM2 high with head entry; dequeue when cnt reaches 0
//   WB_RD   | readM2 high with up_addr; complete read when cnt reaches 0
// -----------------------------------------------------------------------------
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MEM_LATENCY = 4,
  parameter int WORD        = WORD_SIZE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            up_read,
  input  logic            up_write,
  input  logic [WORD-1:0] up_addr,
  input  logic [WORD-1:0] up_wdata,
  output logic [WORD-1:0] up_rdata,
  output logic            up_done,
  output logic            readM2,
  output logic            writeM2,
  output logic [WORD-1:0] address2,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            empty
);

  localparam int            CW       = clog2_min1(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            readM2_q, readM2_d;
  logic            writeM2_q, writeM2_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;

  logic            fifo_full, fifo_empty;
  logic [WORD-1:0] head_addr, head_data;
  logic            fwd_hit;
  logic [WORD-1:0] fwd_data;
  logic            accept, fwd_done, rd_done, pop, read_miss;

  // Full is judged on registered pointers, so a dequeue at this edge does
  // not let a write in during the same cycle.
  assign accept    = up_write && !fifo_full;
  assign fwd_done  = up_read && fwd_hit;
  assign read_miss = up_read && !fwd_hit;
  assign rd_done   = (state_q == WB_RD) && (cnt_q == '0);
  assign pop       = (state_q == WB_WR) && (cnt_q == '0);

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .WORD  (WORD)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (accept),
    .push_addr   (up_addr),
    .push_data   (up_wdata),
    .pop         (pop),
    .lookup_addr (up_addr),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .hit         (fwd_hit),
    .hit_data    (fwd_data)
  );

  assign up_done   = accept || fwd_done || rd_done;
  assign up_rdata  = rd_done  ? mem_rdata :
                     fwd_done ? fwd_data  : '0;
  assign readM2    = readM2_q;
  assign writeM2   = writeM2_q;
  assign address2  = addr_q;
  assign mem_wdata = wdata_q;
  assign empty     = fifo_empty && (state_q == WB_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    readM2_d  = readM2_q;
    writeM2_d = writeM2_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      WB_IDLE: begin
        if (read_miss) begin
          state_d   = WB_RD;
          cnt_d     = CNT_LOAD;
          readM2_d  = 1'b1;
          writeM2_d = 1'b0;
          addr_d    = up_addr;
          wdata_d   = '0;
        end else if (!fifo_empty) begin
          state_d   = WB_WR;
          cnt_d     = CNT_LOAD;
          readM2_d  = 1'b0;
          writeM2_d = 1'b1;
          addr_d    = head_addr;
          wdata_d   = head_data;
        end
      end
      WB_WR, WB_RD: begin
        if (cnt_q == '0) begin
          state_d   = WB_IDLE;
          readM2_d  = 1'b0;
          writeM2_d = 1'b0;
          addr_d    = '0;
          wdata_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d   = WB_IDLE;
        cnt_d     = '0;
        readM2_d  = 1'b0;
        writeM2_d = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WB_IDLE;
      cnt_q     <= '0;
      readM2_q  <= 1'b0;
      writeM2_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      readM2_q  <= readM2_d;
      writeM2_q <= writeM2_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_write_buffer
//   Directed bench for dcache_write_buffer (DEPTH=4, MEM_LATENCY=4, WORD=16).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   later in the cycle or on the falling edge by the memory-port monitor.
// -----------------------------------------------------------------------------
module tb_dcache_write_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        up_read, up_write;
  logic [15:0] up_addr, up_wdata, up_rdata;
  logic        up_done, readM2, writeM2, empty;
  logic [15:0] address2, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(4), .MEM_LATENCY(4), .WORD(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .up_read   (up_read),
    .up_write  (up_write),
    .up_addr   (up_addr),
    .up_wdata  (up_wdata),
    .up_rdata  (up_rdata),
    .up_done   (up_done),
    .readM2    (readM2),
    .writeM2   (writeM2),
    .address2  (address2),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  // Memory model: address 0x0030 holds 0x5A5A, everything else reads ~addr.
  assign mem_rdata = readM2 ? ((address2 == 16'h0030) ? 16'h5A5A : ~address2) : 16'h0000;

  // Memory-port monitor: one event per strobe window (kind 0 = write, 1 = read).
  int          ev_kind [$];
  logic [15:0] ev_addr [$];
  logic [15:0] ev_data [$];
  int          wr_cycles, rd_cycles;
  int          both_hi = 0;
  int          unstable = 0;
  logic        prev_w, prev_r;
  logic [15:0] prev_a, prev_d;

  always @(negedge clk) begin
    if (writeM2 && !prev_w) begin
      ev_kind.push_back(0); ev_addr.push_back(address2); ev_data.push_back(mem_wdata);
    end
    if (readM2 && !prev_r) begin
      ev_kind.push_back(1); ev_addr.push_back(address2); ev_data.push_back(16'h0000);
    end
    if (writeM2 && prev_w && (address2 !== prev_a || mem_wdata !== prev_d)) unstable++;
    if (readM2 && prev_r && address2 !== prev_a) unstable++;
    if (writeM2) wr_cycles++;
    if (readM2) rd_cycles++;
    if (readM2 && writeM2) both_hi++;
    prev_w = writeM2; prev_r = readM2; prev_a = address2; prev_d = mem_wdata;
  end

  task automatic clear_mon();
    ev_kind.delete(); ev_addr.delete(); ev_data.delete();
    wr_cycles = 0; rd_cycles = 0;
    prev_w = 1'b0; prev_r = 1'b0; prev_a = '0; prev_d = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    up_read = 0; up_write = 0; up_addr = 0; up_wdata = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    clear_mon();
  endtask

  // Hold a write until up_done; 'stalls' = cycles seen with up_done low.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int max,
                          output int stalls);
    up_write = 1; up_addr = a; up_wdata = d; stalls = 0;
    #1;
    while (!up_done && stalls < max) begin tick(); #1; stalls++; end
    if (!up_done) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h: up_done never rose within %0d cycles", a, max);
    end
    tick();
    up_write = 0;
  endtask

  // Hold a read until up_done; 'cycles' includes the completing cycle.
  task automatic do_read(input logic [15:0] a, input int max, output int cycles,
                         output logic [15:0] data);
    up_read = 1; up_addr = a; cycles = 1;
    #1;
    while (!up_done && cycles <= max) begin tick(); #1; cycles++; end
    data = up_rdata;
    if (!up_done) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h: up_done never rose within %0d cycles", a, max);
    end
    tick();
    up_read = 0;
  endtask

  task automatic wait_empty(input int max, input string name);
    int n = 0;
    while (!empty && n < max) begin tick(); n++; end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++; $display("FAIL %s: empty=%b after %0d cycles, required 1", name, empty, max);
    end
  endtask

  task automatic test_reset();
    up_read = 0; up_write = 0; up_addr = 0; up_wdata = 0;
    #1 reset_n = 0;
    #2;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b required 1", empty); end
    vectors++; if (up_done !== 1'b0) begin miscompares++; $display("FAIL rst_up_done: got %b required 0", up_done); end
    vectors++; if (readM2 !== 1'b0 || writeM2 !== 1'b0) begin miscompares++; $display("FAIL rst_strobes: rd=%b wr=%b required 0 0", readM2, writeM2); end
    vectors++; if (address2 !== 16'h0 || mem_wdata !== 16'h0) begin miscompares++; $display("FAIL rst_mem_bus: addr=%h wdata=%h required 0000 0000", address2, mem_wdata); end
    vectors++; if (up_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_up_rdata: got %h required 0000", up_rdata); end
    tick();
    reset_n = 1;
    tick();
    vectors++; if (empty !== 1'b1 || writeM2 !== 1'b0) begin miscompares++; $display("FAIL rst_release_idle: empty=%b wr=%b required 1 0", empty, writeM2); end
    clear_mon();
  endtask

  task automatic test_single_write();
    int st;
    apply_reset();
    do_write(16'h0010, 16'h1234, 4, st);
    vectors++; if (st != 0) begin miscompares++; $display("FAIL single_accept_stalls: got %0d required 0", st); end
    vectors++; if (writeM2 !== 1'b0 || empty !== 1'b0) begin miscompares++; $display("FAIL single_idle_cycle: wr=%b empty=%b required 0 0", writeM2, empty); end
    tick();
    vectors++; if (writeM2 !== 1'b1 || address2 !== 16'h0010 || mem_wdata !== 16'h1234) begin miscompares++; $display("FAIL single_wr_start: wr=%b addr=%h data=%h required 1 0010 1234", writeM2, address2, mem_wdata); end
    tick(); tick(); tick();
    vectors++; if (writeM2 !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL single_wr_last: wr=%b empty=%b required 1 0", writeM2, empty); end
    tick();
    vectors++; if (writeM2 !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL single_done: wr=%b empty=%b required 0 1", writeM2, empty); end
    vectors++; if (wr_cycles != 4) begin miscompares++; $display("FAIL single_wr_cycles: got %0d required 4", wr_cycles); end
    vectors++;
    if (ev_kind.size() != 1) begin miscompares++; $display("FAIL single_events: got %0d required 1", ev_kind.size()); end
    else if (ev_kind[0] != 0 || ev_addr[0] !== 16'h0010 || ev_data[0] !== 16'h1234) begin
      miscompares++; $display("FAIL single_event: kind=%0d addr=%h data=%h required 0 0010 1234", ev_kind[0], ev_addr[0], ev_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    int exp_st [5] = '{0, 0, 0, 0, 2};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_write(16'h0100 + 16'(i), 16'hC000 + 16'(i), 10, st);
      vectors++; if (st != exp_st[i]) begin miscompares++; $display("FAIL b2b_stalls[%0d]: got %0d required %0d", i, st, exp_st[i]); end
    end
    wait_empty(40, "b2b_drain");
    vectors++; if (wr_cycles != 20) begin miscompares++; $display("FAIL b2b_wr_cycles: got %0d required 20", wr_cycles); end
    vectors++;
    if (ev_kind.size() != 5) begin miscompares++; $display("FAIL b2b_events: got %0d required 5", ev_kind.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        if (ev_kind[i] != 0 || ev_addr[i] !== 16'h0100 + 16'(i) || ev_data[i] !== 16'hC000 + 16'(i)) begin
          miscompares++; $display("FAIL b2b_order[%0d]: kind=%0d addr=%h data=%h required 0 %h %h", i, ev_kind[i], ev_addr[i], ev_data[i], 16'h0100 + 16'(i), 16'hC000 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_forward();
    int st, c;
    logic [15:0] d;
    apply_reset();
    // Entry currently being drained is still forwarded.
    do_write(16'h0070, 16'hDEAD, 4, st);
    tick();
    do_read(16'h0070, 12, c, d);
    vectors++; if (c != 1 || d !== 16'hDEAD) begin miscompares++; $display("FAIL fwd_draining: cycles=%0d data=%h required 1 DEAD", c, d); end
    do_write(16'h0020, 16'hAAAA, 10, st);
    do_write(16'h0020, 16'hBBBB, 10, st);
    do_read(16'h0020, 12, c, d);
    vectors++; if (c != 1 || d !== 16'hBBBB) begin miscompares++; $display("FAIL fwd_youngest: cycles=%0d data=%h required 1 BBBB", c, d); end
    do_write(16'h0040, 16'h1111, 10, st);
    do_write(16'h0044, 16'h2222, 10, st);
    do_read(16'h0040, 12, c, d);
    vectors++; if (c != 1 || d !== 16'h1111) begin miscompares++; $display("FAIL fwd_older_entry: cycles=%0d data=%h required 1 1111", c, d); end
    wait_empty(60, "fwd_drain");
    vectors++; if (rd_cycles != 0) begin miscompares++; $display("FAIL fwd_no_mem_read: readM2 cycles=%0d required 0", rd_cycles); end
    vectors++; if (ev_kind.size() != 5) begin miscompares++; $display("FAIL fwd_events: got %0d required 5", ev_kind.size()); end
  endtask

  task automatic test_read_miss();
    int st, c;
    logic [15:0] d;
    apply_reset();
    do_read(16'h0030, 12, c, d);
    vectors++; if (c != 5 || d !== 16'h5A5A) begin miscompares++; $display("FAIL miss_idle: cycles=%0d data=%h required 5 5A5A", c, d); end
    vectors++; if (rd_cycles != 4) begin miscompares++; $display("FAIL miss_idle_rd_cycles: got %0d required 4", rd_cycles); end
    do_write(16'h0050, 16'h7777, 4, st);
    tick(); tick();
    do_read(16'h0030, 16, c, d);
    vectors++; if (c != 8 || d !== 16'h5A5A) begin miscompares++; $display("FAIL miss_during_wr: cycles=%0d data=%h required 8 5A5A", c, d); end
    vectors++; if (rd_cycles != 8 || wr_cycles != 4) begin miscompares++; $display("FAIL miss_strobe_cycles: rd=%0d wr=%0d required 8 4", rd_cycles, wr_cycles); end
    vectors++;
    if (ev_kind.size() != 3) begin miscompares++; $display("FAIL miss_events: got %0d required 3", ev_kind.size()); end
    else if (ev_kind[1] != 0 || ev_addr[1] !== 16'h0050 || ev_kind[2] != 1 || ev_addr[2] !== 16'h0030) begin
      miscompares++; $display("FAIL miss_order: k1=%0d a1=%h k2=%0d a2=%h required 0 0050 1 0030", ev_kind[1], ev_addr[1], ev_kind[2], ev_addr[2]);
    end
  endtask

  task automatic test_read_priority();
    int st, c;
    logic [15:0] d;
    int          exp_k [5] = '{0, 1, 0, 0, 0};
    logic [15:0] exp_a [5] = '{16'h0200, 16'h0030, 16'h0201, 16'h0202, 16'h0203};
    apply_reset();
    for (int i = 0; i < 4; i++) do_write(16'h0200 + 16'(i), 16'h3000 + 16'(i), 10, st);
    do_read(16'h0030, 16, c, d);
    vectors++; if (c != 7 || d !== 16'h5A5A) begin miscompares++; $display("FAIL prio_read: cycles=%0d data=%h required 7 5A5A", c, d); end
    wait_empty(60, "prio_drain");
    vectors++;
    if (ev_kind.size() != 5) begin miscompares++; $display("FAIL prio_events: got %0d required 5", ev_kind.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        if (ev_kind[i] != exp_k[i] || ev_addr[i] !== exp_a[i]) begin
          miscompares++; $display("FAIL prio_order[%0d]: kind=%0d addr=%h required %0d %h", i, ev_kind[i], ev_addr[i], exp_k[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int st;
    apply_reset();
    do_write(16'h0060, 16'h9999, 4, st);
    tick(); tick();
    reset_n = 0;
    #1;
    vectors++; if (writeM2 !== 1'b0 || readM2 !== 1'b0) begin miscompares++; $display("FAIL midrst_strobes: wr=%b rd=%b required 0 0", writeM2, readM2); end
    vectors++; if (empty !== 1'b1 || address2 !== 16'h0) begin miscompares++; $display("FAIL midrst_state: empty=%b addr=%h required 1 0000", empty, address2); end
    tick();
    reset_n = 1;
    repeat (10) tick();
    vectors++; if (ev_kind.size() != 1 || wr_cycles != 1) begin miscompares++; $display("FAIL midrst_activity: events=%0d wr_cycles=%0d required 1 1", ev_kind.size(), wr_cycles); end
    vectors++; if (empty !== 1'b1 || writeM2 !== 1'b0) begin miscompares++; $display("FAIL midrst_after: empty=%b wr=%b required 1 0", empty, writeM2); end
  endtask

  task automatic test_protocol();
    vectors++; if (both_hi != 0) begin miscompares++; $display("FAIL proto_exclusive: both strobes high %0d cycles, required 0", both_hi); end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL proto_stable: %0d unstable window cycles, required 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_forward();
    test_read_miss();
    test_read_priority();
    test_reset_mid_drain();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
